// File: rtl/bpss_wr_credit_tracker.sv
// Purpose: credit-limited write-descriptor stage in front of bpss_wr_req, with completion matching, transfer fence and status counters.
// Latency: m_req_valid one cycle after an s_req handshake, 1 descriptor/cycle while credits remain; status counters update one cycle after the event.
// Backpressure: s_req_ready drops when credits are exhausted, while the fence is up, or when the held descriptor is not being taken by m_req_ready.
module bpss_wr_credit_tracker #(
    parameter int N_CREDITS  = 8,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic [VADDR_BITS-1:0] s_req_vaddr,
    input  logic [LEN_BITS-1:0]   s_req_len,
    input  logic                  s_req_ctl,
    input  logic [PID_BITS-1:0]   s_req_pid,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [VADDR_BITS-1:0] m_req_vaddr,
    output logic [LEN_BITS-1:0]   m_req_len,
    output logic                  m_req_ctl,
    output logic [PID_BITS-1:0]   m_req_pid,
    input  logic                  done_valid,
    output logic                  done_ready,
    input  logic                  clear,
    output logic [7:0]            outstanding,
    output logic [63:0]           bytes_issued,
    output logic [31:0]           xfer_cnt,
    output logic                  xfer_done,
    output logic                  busy,
    output logic                  err_underflow
);

    localparam logic [7:0] CREDIT_MAX = 8'(N_CREDITS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic                  ctl;
        logic [PID_BITS-1:0]   pid;
    } desc_t;

    desc_t       s_desc;
    desc_t       desc_q;
    logic        m_vld_q;
    logic [7:0]  outstanding_q;
    logic [0:0]  state_q;
    logic [63:0] bytes_q;
    logic [31:0] xfer_cnt_q;
    logic        err_q;

    logic        fence;
    logic        req_acc;
    logic        req_iss;
    logic        done_evt;
    logic        release_evt;

    assign s_desc.vaddr = s_req_vaddr;
    assign s_desc.len   = s_req_len;
    assign s_desc.ctl   = s_req_ctl;
    assign s_desc.pid   = s_req_pid;

    assign fence    = (state_q == ST_DRAIN);
    assign req_iss  = m_vld_q && m_req_ready;
    assign done_evt = done_valid && done_ready;

    // Fence drops once the last descriptor has left the register and every completion is back.
    assign release_evt = fence && !m_vld_q && (outstanding_q == 8'd0);

    // Credit is taken at acceptance, so the held descriptor already counts against the budget.
    assign s_req_ready = aresetn && (outstanding_q < CREDIT_MAX) && !fence
                         && (!m_vld_q || m_req_ready);
    assign req_acc     = s_req_valid && s_req_ready;
    assign done_ready  = aresetn;

    assign m_req_valid   = m_vld_q;
    assign m_req_vaddr   = desc_q.vaddr;
    assign m_req_len     = desc_q.len;
    assign m_req_ctl     = desc_q.ctl;
    assign m_req_pid     = desc_q.pid;
    assign outstanding   = outstanding_q;
    assign bytes_issued  = bytes_q;
    assign xfer_cnt      = xfer_cnt_q;
    assign err_underflow = err_q;
    assign busy          = (outstanding_q != 8'd0) || fence;
    // Decoded from registered state only, so it is glitch-free and lasts exactly the release cycle.
    assign xfer_done     = aresetn && release_evt;

    // Output register: load on accept, drop valid once the sink takes the descriptor.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_vld_q <= 1'b0;
            desc_q  <= '0;
        end else if (req_acc) begin
            m_vld_q <= 1'b1;
            desc_q  <= s_desc;
        end else if (req_iss) begin
            m_vld_q <= 1'b0;
        end
    end

    // In-flight count: +1 on accept, -1 on completion, saturating at zero.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            outstanding_q <= 8'd0;
        end else begin
            case ({req_acc, done_evt})
                2'b10:   outstanding_q <= outstanding_q + 8'd1;
                2'b01:   if (outstanding_q != 8'd0) outstanding_q <= outstanding_q - 8'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Transfer fence: IDLE -> DRAIN on a last-descriptor accept, back on release.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (req_acc && s_req_ctl) state_q <= ST_DRAIN;
                ST_DRAIN: if (release_evt) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // Byte counter over downstream handshakes; clear wins over a same-cycle add.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            bytes_q <= 64'd0;
        end else if (req_iss) begin
            bytes_q <= bytes_q + 64'(desc_q.len);
        end
    end

    // Completed-transfer counter, stepped on each fence release.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            xfer_cnt_q <= 32'd0;
        end else if (release_evt) begin
            xfer_cnt_q <= xfer_cnt_q + 32'd1;
        end
    end

    // Sticky underflow: a completion with nothing outstanding.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear) begin
            err_q <= 1'b0;
        end else if (done_evt && (outstanding_q == 8'd0)) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bpss_wr_credit_tracker.sv
// Directed bench for bpss_wr_credit_tracker with the default parameters.
// Inputs change 1 ns after the rising edge; checks happen mid-cycle.
// Expected values are hand-computed constants.
module tb_bpss_wr_credit_tracker;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_req_valid;
    logic        s_req_ready;
    logic [47:0] s_req_vaddr;
    logic [27:0] s_req_len;
    logic        s_req_ctl;
    logic [5:0]  s_req_pid;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [47:0] m_req_vaddr;
    logic [27:0] m_req_len;
    logic        m_req_ctl;
    logic [5:0]  m_req_pid;
    logic        done_valid;
    logic        done_ready;
    logic        clear;
    logic [7:0]  outstanding;
    logic [63:0] bytes_issued;
    logic [31:0] xfer_cnt;
    logic        xfer_done;
    logic        busy;
    logic        err_underflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    bpss_wr_credit_tracker dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_vaddr(s_req_vaddr), .s_req_len(s_req_len),
        .s_req_ctl(s_req_ctl), .s_req_pid(s_req_pid),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_vaddr(m_req_vaddr), .m_req_len(m_req_len),
        .m_req_ctl(m_req_ctl), .m_req_pid(m_req_pid),
        .done_valid(done_valid), .done_ready(done_ready),
        .clear(clear), .outstanding(outstanding),
        .bytes_issued(bytes_issued), .xfer_cnt(xfer_cnt),
        .xfer_done(xfer_done), .busy(busy), .err_underflow(err_underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [47:0] va, input logic [27:0] ln,
                             input logic c, input logic [5:0] p);
        s_req_valid = v;
        s_req_vaddr = va;
        s_req_len   = ln;
        s_req_ctl   = c;
        s_req_pid   = p;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " s_req_ready"}, 64'(s_req_ready), 64'd0);
        chk({tag, " done_ready"}, 64'(done_ready), 64'd0);
        chk({tag, " m_req_valid"}, 64'(m_req_valid), 64'd0);
        chk({tag, " m_req_vaddr"}, 64'(m_req_vaddr), 64'd0);
        chk({tag, " m_req_len"}, 64'(m_req_len), 64'd0);
        chk({tag, " m_req_ctl"}, 64'(m_req_ctl), 64'd0);
        chk({tag, " m_req_pid"}, 64'(m_req_pid), 64'd0);
        chk({tag, " outstanding"}, 64'(outstanding), 64'd0);
        chk({tag, " bytes_issued"}, bytes_issued, 64'd0);
        chk({tag, " xfer_cnt"}, 64'(xfer_cnt), 64'd0);
        chk({tag, " xfer_done"}, 64'(xfer_done), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " err_underflow"}, 64'(err_underflow), 64'd0);
    endtask

    initial begin
        aresetn     = 1'b0;
        m_req_ready = 1'b0;
        done_valid  = 1'b0;
        clear       = 1'b0;
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");

        aresetn     = 1'b1;
        m_req_ready = 1'b1;
        #1;
        chk("post-reset done_ready", 64'(done_ready), 64'd1);
        chk("post-reset s_req_ready", 64'(s_req_ready), 64'd1);

        // Full-credit burst: 8 back-to-back accepts
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 48'h1000_0000 + 48'(i * 4096), 28'd4096, 1'b0, 6'(i));
            #1;
            chk($sformatf("burst accept %0d", i), 64'(s_req_ready), 64'd1);
            tick();
        end
        chk("burst outstanding after 8", 64'(outstanding), 64'd8);
        chk("burst m_req_vaddr last", 64'(m_req_vaddr), 64'h1000_7000);
        chk("burst m_req_pid last", 64'(m_req_pid), 64'd7);
        drive_req(1'b1, 48'h2000_0000, 28'd4096, 1'b0, 6'd9);
        tick();
        chk("9th stall s_req_ready", 64'(s_req_ready), 64'd0);
        chk("9th stall outstanding", 64'(outstanding), 64'd8);
        chk("9th stall bytes_issued", bytes_issued, 64'd32768);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        #1;
        chk("re-enable s_req_ready", 64'(s_req_ready), 64'd1);
        chk("re-enable outstanding", 64'(outstanding), 64'd7);
        tick();
        chk("9th accepted outstanding", 64'(outstanding), 64'd8);
        chk("9th accepted m_req_vaddr", 64'(m_req_vaddr), 64'h2000_0000);
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        tick();
        done_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        done_valid = 1'b0;
        chk("burst drained outstanding", 64'(outstanding), 64'd0);
        chk("burst drained busy", 64'(busy), 64'd0);
        chk("burst drained bytes", bytes_issued, 64'd36864);

        // Backpressure: sink stalls for 5 cycles
        m_req_ready = 1'b0;
        drive_req(1'b1, 48'hABCD_0000_1234, 28'h100, 1'b0, 6'd5);
        tick();
        drive_req(1'b1, 48'h0000_DEAD_0000, 28'h200, 1'b0, 6'd6);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d m_req_valid", i), 64'(m_req_valid), 64'd1);
            chk($sformatf("bp%0d m_req_vaddr", i), 64'(m_req_vaddr), 64'hABCD_0000_1234);
            chk($sformatf("bp%0d m_req_len", i), 64'(m_req_len), 64'h100);
            chk($sformatf("bp%0d m_req_pid", i), 64'(m_req_pid), 64'd5);
            chk($sformatf("bp%0d s_req_ready", i), 64'(s_req_ready), 64'd0);
            tick();
        end
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        m_req_ready = 1'b1;
        tick();
        chk("bp release m_req_valid", 64'(m_req_valid), 64'd0);
        chk("bp release bytes", bytes_issued, 64'h9100);
        tick();
        chk("bp single handshake bytes", bytes_issued, 64'h9100);
        chk("bp outstanding", 64'(outstanding), 64'd1);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("bp drained outstanding", 64'(outstanding), 64'd0);

        // Fence: three descriptors, the last one closes the transfer
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 48'h3000 + 48'(i * 16), 28'h10, (i == 2), 6'd1);
            tick();
        end
        chk("fence outstanding", 64'(outstanding), 64'd3);
        chk("fence m_req_ctl", 64'(m_req_ctl), 64'd1);
        drive_req(1'b1, 48'h4000, 28'h10, 1'b0, 6'd2);
        #1;
        chk("fence s_req_ready after last accept", 64'(s_req_ready), 64'd0);
        tick();
        chk("fence s_req_ready issued", 64'(s_req_ready), 64'd0);
        chk("fence xfer_done early", 64'(xfer_done), 64'd0);
        done_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("fence s_req_ready done%0d", i), 64'(s_req_ready), 64'd0);
            chk($sformatf("fence xfer_done done%0d", i), 64'(xfer_done), 64'd0);
            tick();
        end
        done_valid = 1'b0;
        #1;
        chk("fence xfer_done pulse", 64'(xfer_done), 64'd1);
        chk("fence outstanding zero", 64'(outstanding), 64'd0);
        chk("fence s_req_ready at release", 64'(s_req_ready), 64'd0);
        tick();
        chk("fence xfer_done single", 64'(xfer_done), 64'd0);
        chk("fence xfer_cnt", 64'(xfer_cnt), 64'd1);
        chk("fence busy", 64'(busy), 64'd0);
        chk("fence s_req_ready reopened", 64'(s_req_ready), 64'd1);
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);

        // Simultaneous accept and completion at outstanding = 3
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 48'h5000 + 48'(i), 28'h8, 1'b0, 6'd3);
            tick();
        end
        chk("simul pre outstanding", 64'(outstanding), 64'd3);
        drive_req(1'b1, 48'h5003, 28'h8, 1'b0, 6'd3);
        done_valid = 1'b1;
        #1;
        chk("simul s_req_ready", 64'(s_req_ready), 64'd1);
        tick();
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        done_valid = 1'b0;
        chk("simul outstanding", 64'(outstanding), 64'd3);
        done_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        done_valid = 1'b0;
        chk("simul drained", 64'(outstanding), 64'd0);

        // Underflow and clear
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("underflow err", 64'(err_underflow), 64'd1);
        chk("underflow outstanding", 64'(outstanding), 64'd0);
        tick();
        chk("underflow sticky", 64'(err_underflow), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear err", 64'(err_underflow), 64'd0);
        chk("clear bytes", bytes_issued, 64'd0);
        chk("clear xfer_cnt", 64'(xfer_cnt), 64'd0);
        drive_req(1'b1, 48'h6000, 28'h40, 1'b0, 6'd4);
        tick();
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear beats add", bytes_issued, 64'd0);
        tick();
        chk("clear beats add settled", bytes_issued, 64'd0);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("clear test drained", 64'(outstanding), 64'd0);

        // Mid-transfer reset with outstanding = 5 and the fence up
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, 48'h7000 + 48'(i), 28'h20, (i == 4), 6'd7);
            tick();
        end
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        chk("midrst outstanding", 64'(outstanding), 64'd5);
        chk("midrst busy", 64'(busy), 64'd1);
        aresetn = 1'b0;
        tick();
        chk_all_zero("midrst");
        aresetn = 1'b1;
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("late completion underflow", 64'(err_underflow), 64'd1);
        chk("late completion outstanding", 64'(outstanding), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive_req(1'b1, 48'h8000, 28'h80, 1'b1, 6'd8);
        tick();
        drive_req(1'b0, 48'd0, 28'd0, 1'b0, 6'd0);
        chk("resume m_req_valid", 64'(m_req_valid), 64'd1);
        chk("resume outstanding", 64'(outstanding), 64'd1);
        tick();
        chk("resume bytes", bytes_issued, 64'h80);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("resume xfer_done", 64'(xfer_done), 64'd1);
        tick();
        chk("resume xfer_cnt", 64'(xfer_cnt), 64'd1);
        chk("resume busy", 64'(busy), 64'd0);
        chk("resume err cleared", 64'(err_underflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
